// File: rtl/sd_cmd_host_seq_if.sv
// Wishbone master-side bus between sd_cmd_host_seq and the SD controller's 8-bit FIFO register slave.
// Signal names carry the master's point of view (_o driven by the master, _i driven by the slave).
interface sd_cmd_host_seq_if;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/sd_cmd_host_seq.sv
// SD command sequencer: pushes a 6-byte command into the TX cmd FIFO, then drains the response from the RX cmd FIFO.
// Optional build macro SD_CMD_HW_TIMER_EN adds a read of the slave's timeout register (addr 6) to every RX poll.
module sd_cmd_host_seq #(
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  sd_cmd_host_seq_if.master     bus,
  input  logic                  cmd_start_i,
  input  logic [5:0]            cmd_index_i,
  input  logic [31:0]           cmd_arg_i,
  input  logic [1:0]            cmd_rsp_i,
  output logic                  busy_o,
  output logic [7:0]            rsp_dat_o,
  output logic                  rsp_valid_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [2:0]            dbg_state_o
);

  // Bus handshake: a transfer is offered while cyc/stb are high and completes on the
  // clock edge where wb_ack_i is sampled high; address, data and we stay stable until
  // then, and cyc/stb drop for exactly one cycle after every ack so the slave can re-arm.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX_POLL = 3'd1,
    S_TX_WR   = 3'd2,
    S_RX_POLL = 3'd3,
    S_RX_RD   = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  localparam logic [2:0]  ADR_TX   = 3'd0;
  localparam logic [2:0]  ADR_RX   = 3'd1;
  localparam logic [2:0]  ADR_STAT = 3'd4;
`ifdef SD_CMD_HW_TIMER_EN
  localparam logic [2:0]  ADR_TMR  = 3'd6;
`endif
  localparam logic [15:0] POLL_LIM = 16'(POLL_LIMIT);

  state_t      state_q;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [1:0]  rsp_q;
  logic [4:0]  byte_q;
  logic [15:0] poll_q;
  logic        cyc_q;
  logic        we_q;
  logic [2:0]  adr_q;
  logic [7:0]  dat_q;
  logic        busy_q;
  logic [7:0]  rsp_dat_q;
  logic        rsp_valid_q;
  logic        done_q;
  logic        timeout_q;
`ifdef SD_CMD_HW_TIMER_EN
  logic        tmr_ph_q;
  logic        rx_empty_q;
`endif

  logic [15:0] poll_d;
  logic [4:0]  byte_d;
  logic [4:0]  rx_total;
  logic [7:0]  tx_byte;
  logic        poll_expired;

  // Saturating poll count; the limit test uses the incremented value so exactly
  // POLL_LIMIT failed polls are issued before giving up.
  assign poll_d       = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
  assign poll_expired = (poll_d >= POLL_LIM);
  assign byte_d       = byte_q + 5'd1;
  assign rx_total     = (rsp_q == 2'd2) ? 5'd17 : 5'd6;

  always_comb begin
    tx_byte = 8'h00;
    case (byte_q)
      5'd0:    tx_byte = {2'b01, idx_q};
      5'd1:    tx_byte = arg_q[31:24];
      5'd2:    tx_byte = arg_q[23:16];
      5'd3:    tx_byte = arg_q[15:8];
      5'd4:    tx_byte = arg_q[7:0];
      5'd5:    tx_byte = {rsp_q, 6'b000000};
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      arg_q       <= '0;
      rsp_q       <= '0;
      byte_q      <= '0;
      poll_q      <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      busy_q      <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef SD_CMD_HW_TIMER_EN
      tmr_ph_q    <= 1'b0;
      rx_empty_q  <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_start_i) begin
            idx_q     <= cmd_index_i;
            arg_q     <= cmd_arg_i;
            rsp_q     <= cmd_rsp_i;
            timeout_q <= 1'b0;
            byte_q    <= '0;
            poll_q    <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_TX_POLL;
          end
        end

        S_TX_POLL: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= ADR_STAT;
          end else if (bus.wb_ack_i) begin
            cyc_q <= 1'b0;
            if (!bus.wb_dat_i[0]) begin
              state_q <= S_TX_WR;
            end else if (poll_expired) begin
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= S_FIN;
            end else begin
              poll_q <= poll_d;
            end
          end
        end

        S_TX_WR: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            we_q  <= 1'b1;
            adr_q <= ADR_TX;
            dat_q <= tx_byte;
          end else if (bus.wb_ack_i) begin
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            poll_q <= '0;
            if (byte_q == 5'd5) begin
              // The byte counter is reused to count response bytes.
              byte_q <= '0;
              if (rsp_q != 2'd0) begin
                state_q <= S_RX_POLL;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end
            end else begin
              byte_q  <= byte_d;
              state_q <= S_TX_POLL;
            end
          end
        end

        S_RX_POLL: begin
`ifdef SD_CMD_HW_TIMER_EN
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= tmr_ph_q ? ADR_TMR : ADR_STAT;
          end else if (bus.wb_ack_i) begin
            cyc_q <= 1'b0;
            if (!tmr_ph_q) begin
              tmr_ph_q   <= 1'b1;
              rx_empty_q <= bus.wb_dat_i[1];
            end else begin
              tmr_ph_q <= 1'b0;
              // An expired hardware timer overrides the poll budget.
              if (bus.wb_dat_i == 8'h00) begin
                timeout_q <= 1'b1;
                done_q    <= 1'b1;
                state_q   <= S_FIN;
              end else if (!rx_empty_q) begin
                state_q <= S_RX_RD;
              end else if (poll_expired) begin
                timeout_q <= 1'b1;
                done_q    <= 1'b1;
                state_q   <= S_FIN;
              end else begin
                poll_q <= poll_d;
              end
            end
          end
`else
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= ADR_STAT;
          end else if (bus.wb_ack_i) begin
            cyc_q <= 1'b0;
            if (!bus.wb_dat_i[1]) begin
              state_q <= S_RX_RD;
            end else if (poll_expired) begin
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= S_FIN;
            end else begin
              poll_q <= poll_d;
            end
          end
`endif
        end

        S_RX_RD: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= ADR_RX;
          end else if (bus.wb_ack_i) begin
            cyc_q       <= 1'b0;
            rsp_dat_q   <= bus.wb_dat_i;
            rsp_valid_q <= 1'b1;
            poll_q      <= '0;
            if (byte_d == rx_total) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              byte_q  <= byte_d;
              state_q <= S_RX_POLL;
            end
          end
        end

        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;

  assign busy_o      = busy_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sd_cmd_host_seq.sv
// Directed bench for sd_cmd_host_seq against a 2-cycle-ack FIFO register slave model.
// Build with SD_CMD_HW_TIMER_EN defined to also exercise the hardware-timer timeout.
module tb_sd_cmd_host_seq;

  logic        clk;
  logic        rst;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  cmd_rsp;
  logic        busy;
  logic [7:0]  rsp_dat;
  logic        rsp_valid;
  logic        done;
  logic        timeout;
  logic [2:0]  dbg_state;

  int vecs  = 0;
  int fails = 0;

  sd_cmd_host_seq_if bus ();

  sd_cmd_host_seq #(.POLL_LIMIT(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .bus         (bus),
    .cmd_start_i (cmd_start),
    .cmd_index_i (cmd_index),
    .cmd_arg_i   (cmd_arg),
    .cmd_rsp_i   (cmd_rsp),
    .busy_o      (busy),
    .rsp_dat_o   (rsp_dat),
    .rsp_valid_o (rsp_valid),
    .done_o      (done),
    .timeout_o   (timeout),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: acks on the third stb cycle, ack low again the cycle after.
  logic [7:0]  rx_q[$];
  int          full_req   = 0;
  int          full_given = 0;
  logic [7:0]  timer_val  = 8'h55;
  logic        ack_q;
  logic [7:0]  rdata_q;
  logic [1:0]  dly_q;

  assign bus.wb_ack_i = ack_q;
  assign bus.wb_dat_i = rdata_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      dly_q   <= 2'd0;
      rdata_q <= 8'h00;
    end else if (bus.wb_cyc_o && bus.wb_stb_o && !ack_q) begin
      if (dly_q == 2'd1) begin
        ack_q <= 1'b1;
        dly_q <= 2'd0;
        if (!bus.wb_we_o) begin
          case (bus.wb_adr_o)
            3'd4: begin
              rdata_q <= {6'b0, (rx_q.size() == 0), (full_given < full_req)};
              if (full_given < full_req) full_given = full_given + 1;
            end
            3'd1:    rdata_q <= (rx_q.size() != 0) ? rx_q.pop_front() : 8'hEE;
            3'd6:    rdata_q <= timer_val;
            default: rdata_q <= 8'h00;
          endcase
        end
      end else begin
        dly_q <= dly_q + 2'd1;
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected TX bytes and response bytes
  logic [7:0] exp_q[$];
  logic [7:0] exp_rsp_q[$];
  logic       tx_chk = 1'b1;
  int wr_cnt = 0, stat_cnt = 0, tmr_cnt = 0, rsp_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
      if (bus.wb_we_o && bus.wb_adr_o == 3'd0) begin
        wr_cnt++;
        if (tx_chk) begin
          chk("tx_q_avail", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) chk("tx_byte", {24'b0, bus.wb_dat_o}, {24'b0, exp_q.pop_front()});
        end
      end
      if (!bus.wb_we_o && bus.wb_adr_o == 3'd4) stat_cnt++;
      if (!bus.wb_we_o && bus.wb_adr_o == 3'd6) tmr_cnt++;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      chk("rsp_q_avail", 32'(exp_rsp_q.size() > 0), 32'd1);
      if (exp_rsp_q.size() > 0) chk("rsp_byte", {24'b0, rsp_dat}, {24'b0, exp_rsp_q.pop_front()});
    end
    if (done) done_cnt++;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rsp);
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_rsp   = rsp;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
  endtask

  task automatic push_tx(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rsp);
    exp_q.push_back({2'b01, idx});
    exp_q.push_back(arg[31:24]);
    exp_q.push_back(arg[23:16]);
    exp_q.push_back(arg[15:8]);
    exp_q.push_back(arg[7:0]);
    exp_q.push_back({rsp, 6'b0});
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cyc"}, {31'b0, bus.wb_cyc_o}, 32'd0);
    chk({tag, "_stb"}, {31'b0, bus.wb_stb_o}, 32'd0);
    chk({tag, "_we"}, {31'b0, bus.wb_we_o}, 32'd0);
    chk({tag, "_adr_dat"}, {21'b0, bus.wb_adr_o, bus.wb_dat_o}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_rsp"}, {23'b0, rsp_valid, rsp_dat}, 32'd0);
    chk({tag, "_done_to"}, {30'b0, done, timeout}, 32'd0);
    chk({tag, "_state"}, {29'b0, dbg_state}, 32'd0);
  endtask

  int n;
  int b_wr, b_stat, b_tmr, b_rsp, b_done;

  task automatic mark();
    b_wr = wr_cnt; b_stat = stat_cnt; b_tmr = tmr_cnt; b_rsp = rsp_cnt; b_done = done_cnt;
  endtask

  initial begin
    rst = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; cmd_rsp = '0;
    repeat (3) step();
    check_reset_vals("rst_hold");
    rst = 1'b0;
    step();

    // Reset mid TX write
    tx_chk = 1'b0;
    start_cmd(6'd0, 32'h0, 2'd0);
    n = 0;
    while (!(dbg_state == 3'd2 && bus.wb_cyc_o) && n < 200) begin step(); n++; end
    chk("reach_tx_wr", {31'b0, bus.wb_cyc_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_cyc", {30'b0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
    chk("rst_async_busy", {31'b0, busy}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    check_reset_vals("rst_mid");
    tx_chk = 1'b1;

    // CMD0, no response: 12 accesses of 4 cycles each
    mark();
    push_tx(6'd0, 32'h0, 2'd0);
    start_cmd(6'd0, 32'h0, 2'd0);
    chk("cmd0_busy", {31'b0, busy}, 32'd1);
    wait_done(n);
    chk("cmd0_latency", n, 32'd48);
    step();
    chk("cmd0_done_pulse", {31'b0, done}, 32'd0);
    chk("cmd0_busy_low", {31'b0, busy}, 32'd0);
    repeat (3) step();
    chk("cmd0_writes", wr_cnt - b_wr, 32'd6);
    chk("cmd0_stat", stat_cnt - b_stat, 32'd6);
    chk("cmd0_rsp_none", rsp_cnt - b_rsp, 32'd0);
    chk("cmd0_done_cnt", done_cnt - b_done, 32'd1);
    chk("cmd0_txq_empty", exp_q.size(), 32'd0);

    // CMD17, short response
    mark();
    push_tx(6'd17, 32'h0000_1234, 2'd1);
    foreach (exp_rsp_q[i]) ; // queue is empty here
    begin
      logic [7:0] r[6];
      r = '{8'h11, 8'h00, 8'h00, 8'h09, 8'h00, 8'h01};
      for (int i = 0; i < 6; i++) begin rx_q.push_back(r[i]); exp_rsp_q.push_back(r[i]); end
    end
    start_cmd(6'd17, 32'h0000_1234, 2'd1);
    wait_done(n);
    step();
    repeat (3) step();
    chk("cmd17_rsp_cnt", rsp_cnt - b_rsp, 32'd6);
    chk("cmd17_rsp_hold", {24'b0, rsp_dat}, 32'h01);
    chk("cmd17_timeout", {31'b0, timeout}, 32'd0);
    chk("cmd17_queues", exp_q.size() + exp_rsp_q.size(), 32'd0);

    // CMD2, long response, TX full for 3 polls, ignored start mid-sequence
    mark();
    full_req = full_given + 3;
    push_tx(6'd2, 32'h0, 2'd2);
    rx_q.push_back(8'h3F); exp_rsp_q.push_back(8'h3F);
    for (int i = 1; i <= 16; i++) begin rx_q.push_back(8'(i)); exp_rsp_q.push_back(8'(i)); end
    start_cmd(6'd2, 32'h0, 2'd2);
    n = 0;
    while (wr_cnt == b_wr && n < 500) begin step(); n++; end
    chk("cmd2_stat_before_wr", stat_cnt - b_stat, 32'd4);
    n = 0;
    while (rsp_cnt - b_rsp < 5 && n < 1000) begin step(); n++; end
    chk("cmd2_mid_busy", {31'b0, busy}, 32'd1);
    start_cmd(6'd5, 32'hFFFF_FFFF, 2'd0);
    wait_done(n);
    repeat (20) step();
    chk("cmd2_rsp_cnt", rsp_cnt - b_rsp, 32'd17);
    chk("cmd2_writes", wr_cnt - b_wr, 32'd6);
    chk("cmd2_done_cnt", done_cnt - b_done, 32'd1);
    chk("cmd2_idle", {31'b0, busy}, 32'd0);
    chk("cmd2_queues", exp_q.size() + exp_rsp_q.size(), 32'd0);

    // Poll-limit timeout: RX stays empty
    mark();
    push_tx(6'd13, 32'hA5A5_0F0F, 2'd1);
    start_cmd(6'd13, 32'hA5A5_0F0F, 2'd1);
    wait_done(n);
    chk("to_flag", {31'b0, timeout}, 32'd1);
    step();
    chk("to_stat", stat_cnt - b_stat, 32'd10);
    chk("to_rsp_none", rsp_cnt - b_rsp, 32'd0);
    chk("to_sticky", {30'b0, timeout, busy}, 32'd2);

    // Next start clears the sticky timeout
    mark();
    push_tx(6'd0, 32'h0, 2'd0);
    start_cmd(6'd0, 32'h0, 2'd0);
    chk("to_cleared", {31'b0, timeout}, 32'd0);
    wait_done(n);
    step();
    chk("to_clear_done", {30'b0, timeout, busy}, 32'd0);

`ifdef SD_CMD_HW_TIMER_EN
    // Hardware timer reports expiry on the first RX poll
    mark();
    timer_val = 8'h00;
    push_tx(6'd8, 32'h0000_01AA, 2'd1);
    start_cmd(6'd8, 32'h0000_01AA, 2'd1);
    wait_done(n);
    chk("hwt_flag", {31'b0, timeout}, 32'd1);
    step();
    chk("hwt_stat", stat_cnt - b_stat, 32'd7);
    chk("hwt_tmr", tmr_cnt - b_tmr, 32'd1);
    timer_val = 8'h55;
`else
    chk("no_tmr_access", tmr_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/sd_cmd_host_seq.md
# sd_cmd_host_seq

Wishbone bus-master sequencer sitting directly upstream of the SD controller's 8-bit FIFO register slave. It turns a single command request (index, argument, response type) into the byte stream pushed into the TX command FIFO. It then polls status and drains the response bytes from the RX command FIFO, presenting them on a simple valid-strobe output. This removes byte-level polling from software and from the data-path DMA.

## Interface
- POLL_LIMIT, 255 — max consecutive status polls per byte before timeout (1..65535)
- wb_clk_i  in  1  clock; the SD side runs on the same clock (SD_CLK_BUS_CLK build)
- wb_rst_i  in  1  asynchronous, active-high reset
- wb_adr_o  out  3  slave address: 0 TX cmd FIFO, 1 RX cmd FIFO, 4 status, 6 timer
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_we_o  out  1  write enable
- wb_cyc_o / wb_stb_o  out  1 each  bus cycle / strobe, always driven equal
- wb_ack_i  in  1  slave acknowledge
- cmd_start_i  in  1  one-cycle request; sampled only in IDLE
- cmd_index_i  in  6  SD command index
- cmd_arg_i  in  32  SD command argument
- cmd_rsp_i  in  2  0 none, 1 short (6 bytes), 2 long (17 bytes), 3 treated as 1
- busy_o  out  1  high from the accepted start until the done_o cycle inclusive
- rsp_dat_o  out  8  response byte
- rsp_valid_o  out  1  one-cycle strobe qualifying rsp_dat_o
- done_o  out  1  one-cycle completion pulse
- timeout_o  out  1  sticky error; cleared on next accepted start

## Operation
- Command bytes, in order: {2'b01,index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {rsp[1:0],6'b0}. Index, argument and rsp are latched on the accepted start.
- States: IDLE, TX_POLL, TX_WR, RX_POLL, RX_RD, FIN.
- IDLE: on cmd_start_i, latch inputs, clear timeout_o, clear byte and poll counters, go to TX_POLL.
- TX_POLL: read addr 4. If bit0 (TX full) = 0, go to TX_WR. Otherwise increment the poll counter and repeat.
- TX_WR: write the current byte to addr 0, reset the poll counter, advance the byte counter.
  - After byte 5: go to RX_POLL if rsp != 0, else FIN.
  - Otherwise return to TX_POLL.
- RX_POLL: read addr 4. If bit1 (RX empty) = 0, go to RX_RD. Otherwise increment the poll counter and repeat.
- RX_RD: read addr 1, present the byte, reset the poll counter. Go to FIN after the 6th byte (short) or 17th byte (long); else return to RX_POLL.
- Timeout: a poll counter reaching POLL_LIMIT with the condition still unmet sets timeout_o and goes to FIN. Bytes not yet sent or received are abandoned.
- FIN: pulse done_o for one cycle, return to IDLE.
- cmd_start_i while busy: ignored, with no effect on latched fields.
- Byte counter is 5 bits. Poll counter is 16 bits, saturating, compared with `>=`.

## Timing
- Reset values: wb_cyc_o = wb_stb_o = wb_we_o = 0, wb_adr_o = 0, wb_dat_o = 0, busy_o = 0, rsp_dat_o = 0, rsp_valid_o = 0, done_o = 0, timeout_o = 0, state IDLE.
- Bus access:
  - cyc/stb/adr/we/dat are registered and asserted from the cycle after the state is entered.
  - They are held stable until wb_ack_i is sampled high.
  - Read data is captured on the ack cycle.
  - cyc/stb are low for exactly one cycle after each ack, because the slave needs ~ack before it re-arms.
- Against the 2-cycle-ack slave, each access is 4 cycles (3 with stb high + 1 gap).
- A no-response command with no full stalls takes 12 accesses.
- rsp_valid_o is asserted in the cycle after the RX_RD ack, with rsp_dat_o holding the captured byte. rsp_dat_o holds its value until the next strobe.
- done_o is asserted in the cycle after the last ack or after the timeout decision. busy_o drops the cycle after done_o.
- Reset mid-access: outputs go to their reset values asynchronously and cyc/stb drop immediately; no partial state is retained.

## Configuration
- SD_CMD_HW_TIMER_EN defined:
  - Each RX_POLL additionally reads addr 6 (the slave's command timeout register), as one extra access after the status read.
  - A value of 0 sets timeout_o immediately, independent of POLL_LIMIT.
- SD_CMD_HW_TIMER_EN undefined: addr 6 is never accessed; the timeout comes from POLL_LIMIT only.

## Test plan
- Reset asserted mid-TX_WR -> cyc/stb = 0 at once, busy_o = 0; all outputs at their reset values after release.
- CMD0, arg 0, rsp 0; slave model never full -> addr-0 writes 0x40,00,00,00,00,0x00; done_o one pulse; zero rsp_valid_o pulses; busy_o low afterwards.
- CMD17, arg 0x00001234, rsp 1; model returns 0x11,00,00,09,00,0x01 -> writes 0x51,00,00,12,34,0x40; six rsp_valid_o pulses carrying those bytes in order; then done_o.
- CMD2, rsp 2; model holds TX full for 3 polls before byte 0 and supplies 17 bytes 0x3F,0x01..0x10 -> exactly 4 status reads before the first write; 17 strobes in order; a cmd_start_i issued mid-sequence is ignored.
- rsp 1, RX empty forever, POLL_LIMIT = 4 -> 4 status reads after the last write, then timeout_o = 1 and done_o pulse. A following start clears timeout_o.
- With SD_CMD_HW_TIMER_EN and the timer register returning 0 on the first RX poll -> timeout_o = 1 after one status read plus one addr-6 read.
